// File: rtl/cam_arbiter_pkg.sv
// cam_arbiter_pkg: shared types and helpers for the CAM arbiter
package cam_arbiter_pkg;
   localparam int CAM_ARB_MAX_REQ = 4;
   typedef struct packed {
      logic       valid;
      logic [1:0] owner;
      logic       rw_n;
   } cam_arb_tag_t;
   function automatic logic [1:0] next_idx(input logic [1:0] i, input int n);
      return (int'(i) == n - 1) ? 2'd0 : i + 2'd1;
   endfunction
endpackage

// File: rtl/cam_arbiter_if.sv
// cam_arbiter_if: requester handshake, response and CAM port bundle
interface cam_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int KEY_WIDTH = 16,
   parameter int VAL_WIDTH = 16
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           req_rw_n;
   logic [NUM_REQ*KEY_WIDTH-1:0] req_key;
   logic [NUM_REQ*VAL_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]           req_lock;
   logic [NUM_REQ-1:0]           resp_valid;
   logic                         resp_write;
   logic                         resp_hit;
   logic [VAL_WIDTH-1:0]         resp_rdata;
   logic                         cam_valid_i;
   logic                         cam_rw_n;
   logic [KEY_WIDTH-1:0]         cam_key;
   logic [VAL_WIDTH-1:0]         cam_wdata;
   logic                         cam_valid_o;
   logic [VAL_WIDTH-1:0]         cam_rdata;
   modport slave (
      input  req_valid, req_rw_n, req_key, req_wdata, req_lock, cam_valid_o, cam_rdata,
      output req_ready, resp_valid, resp_write, resp_hit, resp_rdata,
             cam_valid_i, cam_rw_n, cam_key, cam_wdata
   );
   modport master (
      output req_valid, req_rw_n, req_key, req_wdata, req_lock, cam_valid_o, cam_rdata,
      input  req_ready, resp_valid, resp_write, resp_hit, resp_rdata,
             cam_valid_i, cam_rw_n, cam_key, cam_wdata
   );
endinterface

// File: rtl/cam_arbiter_rr.sv
// cam_rr_arbiter: round-robin pick of the first valid requester starting at ptr
module cam_rr_arbiter import cam_arbiter_pkg::*; #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         idx,
   output logic               any
);
   logic [CAM_ARB_MAX_REQ-1:0] v4;
   logic [1:0]                 c;
   assign v4 = CAM_ARB_MAX_REQ'(valid);
   // scan from ptr with wrap; the first valid candidate wins
   always_comb begin
      any = 1'b0;
      idx = '0;
      c   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         c = 2'((int'(ptr) + i) % NUM_REQ);
         if (!any && v4[c]) begin
            any = 1'b1;
            idx = c;
         end
      end
      grant = any ? NUM_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/cam_arbiter.sv
// cam_arbiter: shares one CAM among requesters and routes results back to the issuer
module cam_arbiter import cam_arbiter_pkg::*; #(
   parameter int NUM_REQ   = 2,
   parameter int KEY_WIDTH = 16,
   parameter int VAL_WIDTH = 16,
   parameter int CAM_LAT   = 1,
   parameter int LOCK_MAX  = 4
) (
   input logic         clk,
   input logic         rst,
   cam_arbiter_if.slave bus
);
   localparam int LCW = LOCK_MAX > 1 ? $clog2(LOCK_MAX) : 1;
   logic [NUM_REQ-1:0]         grant;
   logic [1:0]                 gidx, rr_ptr, ptr_nxt;
   logic                       any, hs, rd_hit;
   logic [LCW-1:0]             lock_cnt, cnt_nxt;
   logic [CAM_ARB_MAX_REQ-1:0] lock4, rw4;
   logic [KEY_WIDTH-1:0]       sel_key;
   logic [VAL_WIDTH-1:0]       sel_wdata;
   cam_arb_tag_t               tag_pipe [CAM_LAT+1];
   cam_arb_tag_t               tag_out;
   cam_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid(bus.req_valid),
      .ptr  (rr_ptr),
      .grant(grant),
      .idx  (gidx),
      .any  (any)
   );
   assign bus.req_ready = rst ? '0 : grant;
   assign hs            = any & ~rst;
   assign lock4         = CAM_ARB_MAX_REQ'(bus.req_lock);
   assign rw4           = CAM_ARB_MAX_REQ'(bus.req_rw_n);
   assign tag_out       = tag_pipe[CAM_LAT];
   assign rd_hit        = tag_out.valid & tag_out.rw_n & bus.cam_valid_o;
   // a locked winner keeps priority until LOCK_MAX grants in a row, else pass it on
   always_comb begin
      ptr_nxt = rr_ptr;
      cnt_nxt = '0;
      if (hs && lock4[gidx] && lock_cnt < LCW'(LOCK_MAX - 1)) begin
         ptr_nxt = gidx;
         cnt_nxt = lock_cnt + LCW'(1);
      end else if (hs)
         ptr_nxt = next_idx(gidx, NUM_REQ);
   end
   // select the granted requester's key and write value
   always_comb begin
      sel_key   = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gidx == 2'(i)) begin
            sel_key   = bus.req_key[i*KEY_WIDTH +: KEY_WIDTH];
            sel_wdata = bus.req_wdata[i*VAL_WIDTH +: VAL_WIDTH];
         end
   end
   // pointer and lock counter state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rr_ptr   <= '0;
         lock_cnt <= '0;
      end else begin
         rr_ptr   <= ptr_nxt;
         lock_cnt <= cnt_nxt;
      end
   // register the granted op onto the CAM port; operands hold when idle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.cam_valid_i <= 1'b0;
         bus.cam_rw_n    <= 1'b0;
         bus.cam_key     <= '0;
         bus.cam_wdata   <= '0;
      end else begin
         bus.cam_valid_i <= hs;
         if (hs) begin
            bus.cam_rw_n  <= rw4[gidx];
            bus.cam_key   <= sel_key;
            bus.cam_wdata <= sel_wdata;
         end
      end
   // owner tags ride alongside the CAM latency, never stalling
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int k = 0; k <= CAM_LAT; k++) tag_pipe[k] <= '0;
      else begin
         tag_pipe[0] <= '{valid: hs, owner: gidx, rw_n: rw4[gidx]};
         for (int k = 1; k <= CAM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   // one-hot response to the owner, data forced to zero on miss or write
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.resp_valid <= '0;
         bus.resp_write <= 1'b0;
         bus.resp_hit   <= 1'b0;
         bus.resp_rdata <= '0;
      end else begin
         bus.resp_valid <= tag_out.valid ? NUM_REQ'(1) << tag_out.owner : '0;
         bus.resp_write <= tag_out.valid & ~tag_out.rw_n;
         bus.resp_hit   <= rd_hit;
         bus.resp_rdata <= rd_hit ? bus.cam_rdata : '0;
      end
   // an owner beyond NUM_REQ would mean the grant logic is broken
   always_comb
      if (tag_out.valid) assert (int'(tag_out.owner) < NUM_REQ);
endmodule

// File: tb/tb_cam_arbiter.sv
// tb_cam_arbiter: directed scoreboard bench for cam_arbiter with a behavioural CAM
module tb_cam_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nchk = 0;
   int   npass = 0;
   int   cyc = 0;
   logic [19:0] exp_q [$];
   int          cyc_q [$];
   int          glog [$];
   int          glog3 [$];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] cam_mem [logic [15:0]];
   logic        prev_hs = 1'b0;
   logic        prev_rw = 1'b0;
   logic [15:0] prev_key = '0;
   logic [15:0] prev_wdata = '0;
   int exp2 [6]  = '{0, 1, 0, 1, 0, 1};
   int exp3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   int exp6 [6]  = '{0, 1, 2, 0, 2, 0};
   always #5 clk = ~clk;
   cam_arbiter_if #(.NUM_REQ(2), .KEY_WIDTH(16), .VAL_WIDTH(16)) b2 ();
   cam_arbiter_if #(.NUM_REQ(3), .KEY_WIDTH(16), .VAL_WIDTH(16)) b3 ();
   cam_arbiter #(.NUM_REQ(2), .KEY_WIDTH(16), .VAL_WIDTH(16), .CAM_LAT(1), .LOCK_MAX(4)) dut (
      .clk(clk), .rst(rst), .bus(b2.slave)
   );
   cam_arbiter #(.NUM_REQ(3), .KEY_WIDTH(16), .VAL_WIDTH(16), .CAM_LAT(1), .LOCK_MAX(4)) dut3 (
      .clk(clk), .rst(rst), .bus(b3.slave)
   );
   // behavioural CAM, one cycle read latency; rdata is junk on a miss
   always @(posedge clk or posedge rst)
      if (rst) begin
         b2.cam_valid_o <= 1'b0;
         b2.cam_rdata   <= '0;
      end else begin
         b2.cam_valid_o <= 1'b0;
         b2.cam_rdata   <= 16'hDEAD;
         if (b2.cam_valid_i && b2.cam_rw_n && cam_mem.exists(b2.cam_key)) begin
            b2.cam_valid_o <= 1'b1;
            b2.cam_rdata   <= cam_mem[b2.cam_key];
         end
         if (b2.cam_valid_i && !b2.cam_rw_n) cam_mem[b2.cam_key] = b2.cam_wdata;
      end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input int i, input logic v, input logic rw, input logic [15:0] k,
                        input logic [15:0] d, input logic l);
      b2.req_valid[i]       = v;
      b2.req_rw_n[i]        = rw;
      b2.req_key[i*16 +: 16]   = k;
      b2.req_wdata[i*16 +: 16] = d;
      b2.req_lock[i]        = l;
   endtask

   task automatic tick();
      logic [19:0] e;
      int g;
      @(negedge clk);
      cyc++;
      if (rst) begin
         check("ready_in_rst", 32'(b2.req_ready), 0);
         check("resp_in_rst", 32'({b2.resp_valid, b2.resp_write, b2.resp_hit, b2.resp_rdata}), 0);
         check("cam_valid_in_rst", 32'(b2.cam_valid_i), 0);
         exp_q.delete();
         cyc_q.delete();
         prev_hs = 1'b0;
      end else begin
         check("cam_valid_i", 32'(b2.cam_valid_i), 32'(prev_hs));
         if (prev_hs) begin
            check("cam_rw_n", 32'(b2.cam_rw_n), 32'(prev_rw));
            check("cam_key", 32'(b2.cam_key), 32'(prev_key));
            if (!prev_rw) check("cam_wdata", 32'(b2.cam_wdata), 32'(prev_wdata));
         end
         if (exp_q.size() != 0 && cyc - cyc_q[0] == 3) begin
            check("resp", 32'({b2.resp_valid, b2.resp_write, b2.resp_hit, b2.resp_rdata}), 32'(exp_q.pop_front()));
            void'(cyc_q.pop_front());
         end else
            check("resp_idle", 32'({b2.resp_valid, b2.resp_write, b2.resp_hit, b2.resp_rdata}), 0);
         check("ready_onehot", 32'($countones(b2.req_ready) <= 1), 1);
         check("ready3_onehot", 32'($countones(b3.req_ready) <= 1), 1);
         prev_hs = 1'b0;
         if ((b2.req_valid & b2.req_ready) != 0) begin
            g = b2.req_ready[1] ? 1 : 0;
            glog.push_back(g);
            prev_hs    = 1'b1;
            prev_rw    = b2.req_rw_n[g];
            prev_key   = b2.req_key[g*16 +: 16];
            prev_wdata = b2.req_wdata[g*16 +: 16];
            if (prev_rw)
               e = {2'(1 << g), 1'b0, 1'(ref_mem.exists(prev_key)),
                    ref_mem.exists(prev_key) ? ref_mem[prev_key] : 16'h0000};
            else begin
               ref_mem[prev_key] = prev_wdata;
               e = {2'(1 << g), 1'b1, 1'b0, 16'h0000};
            end
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
         end
         for (int i = 0; i < 3; i++)
            if (b3.req_valid[i] && b3.req_ready[i]) glog3.push_back(i);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      b2.req_valid = '0; b2.req_rw_n = '0; b2.req_key = '0; b2.req_wdata = '0; b2.req_lock = '0;
      b3.req_valid = '0; b3.req_rw_n = '0; b3.req_key = '0; b3.req_wdata = '0; b3.req_lock = '0;
      b3.cam_valid_o = 1'b0;
      b3.cam_rdata   = '0;
      drive(0, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0);
      tick();
      tick();
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b0;
      // write then read back from a single requester
      drive(0, 1'b1, 1'b0, 16'h0012, 16'hBEEF, 1'b0);
      tick();
      drive(0, 1'b1, 1'b1, 16'h0012, 16'h0000, 1'b0);
      tick();
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (4) tick();
      check("t1_grants", 32'(glog.size()), 2);
      // read miss from requester 1
      drive(1, 1'b1, 1'b1, 16'h7777, 16'h0000, 1'b0);
      tick();
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (4) tick();
      // two requesters, no lock: alternate, write-then-read ordering
      glog.delete();
      drive(0, 1'b1, 1'b0, 16'h0020, 16'h1111, 1'b0);
      drive(1, 1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0);
      repeat (6) tick();
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      check("t2_count", 32'(glog.size()), 6);
      for (int i = 0; i < 6 && i < glog.size(); i++)
         check($sformatf("t2_grant%0d", i), 32'(glog[i]), 32'(exp2[i]));
      repeat (4) tick();
      // locked requester 0 against requester 1
      glog.delete();
      drive(0, 1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1);
      drive(1, 1'b1, 1'b0, 16'h0030, 16'h2222, 1'b0);
      repeat (10) tick();
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      check("t3_count", 32'(glog.size()), 10);
      for (int i = 0; i < 10 && i < glog.size(); i++)
         check($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'(exp3[i]));
      repeat (4) tick();
      check("drain", 32'(exp_q.size()), 0);
      // reset with two reads in flight
      drive(0, 1'b1, 1'b1, 16'h0030, 16'h0000, 1'b0);
      tick();
      tick();
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      glog.delete();
      drive(0, 1'b1, 1'b1, 16'h0012, 16'h0000, 1'b0);
      drive(1, 1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0);
      tick();
      check("t5_first_grant", glog.size() > 0 ? 32'(glog[0]) : 32'hFFFF_FFFF, 0);
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (4) tick();
      check("drain2", 32'(exp_q.size()), 0);
      // three requesters, requester 1 leaves after its first grant
      glog3.delete();
      b3.req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (glog3.size() > 0 && glog3[$] == 1) b3.req_valid[1] = 1'b0;
      end
      b3.req_valid = '0;
      check("t6_count", 32'(glog3.size()), 6);
      for (int i = 0; i < 6 && i < glog3.size(); i++)
         check($sformatf("t6_grant%0d", i), 32'(glog3[i]), 32'(exp6[i]));
      tick();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
